modular_multiplier_seq: RTL and testbench

Iterative interleaved modular multiplier computing (a · b) mod Q for 30-bit operands, one multiplier bit per clock, MSB first. Sits directly upstream of the modular adder in the NTT butterfly datapath and produces the twiddle products that the adder consumes. Modulus selection uses the same 4-bit index into the shared prime ROM as the adder, so both stages agree on Q. Start/done handshake; fixed 31-cycle latency from start to done.

---
 rtl/modular_multiplier_seq.sv | 150 +++++++++++++++
 tb/tb_modular_multiplier_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/modular_multiplier_seq.sv
// Iterative interleaved modular multiplier: c = (a * b) mod Q, one multiplier bit per clock, MSB first.
// Q is taken from the shared 16-entry prime ROM and frozen at accept so in-flight results are stable.

module prime_rom #(
  parameter int WIDTH = 30
) (
  input  logic [3:0]       index,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = '0;
    case (index)
      4'd0:  q = WIDTH'(32'd998244353);
      4'd1:  q = WIDTH'(32'd469762049);
      4'd2:  q = WIDTH'(32'd167772161);
      4'd3:  q = WIDTH'(32'd754974721);
      4'd4:  q = WIDTH'(32'd1004535809);
      4'd5:  q = WIDTH'(32'd1012924417);
      4'd6:  q = WIDTH'(32'd924844033);
      4'd7:  q = WIDTH'(32'd962592769);
      4'd8:  q = WIDTH'(32'd950009857);
      4'd9:  q = WIDTH'(32'd943718401);
      4'd10: q = WIDTH'(32'd935329793);
      4'd11: q = WIDTH'(32'd897581057);
      4'd12: q = WIDTH'(32'd880803841);
      4'd13: q = WIDTH'(32'd645922817);
      4'd14: q = WIDTH'(32'd595591169);
      4'd15: q = WIDTH'(32'd1073479681);
      default: q = '0;
    endcase
  end

endmodule

module modular_multiplier_seq #(
  parameter int WIDTH = 30,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mod_sel,
  input  logic [3:0]       mod_index,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       mod_idx_reg;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] a_reg, b_reg, q_reg, r_reg, c_reg;
  logic [CW-1:0]    cnt_reg;
  logic             accept, last_iter;
  logic [WIDTH:0]   q_ext, r1_dbl, r1, r2_sum;
  logic [WIDTH-1:0] r2;

  prime_rom #(.WIDTH(WIDTH)) u_prime_rom (
    .index (mod_idx_reg),
    .q     (q)
  );

  // Both reduction steps work at WIDTH+1 bits so 2r and r1+a never wrap before the compare.
  always_comb begin
    q_ext  = {1'b0, q_reg};
    r1_dbl = {r_reg, 1'b0};
    r1     = (r1_dbl >= q_ext) ? (r1_dbl - q_ext) : r1_dbl;
    r2_sum = r1 + (b_reg[cnt_reg] ? {1'b0, a_reg} : '0);
    r2     = WIDTH'((r2_sum >= q_ext) ? (r2_sum - q_ext) : r2_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last_iter  = (cnt_reg == '0);
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mod_idx_reg <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      c_reg       <= '0;
      cnt_reg     <= '0;
    end else begin
      // The index register is locked while an operation is in flight.
      if (mod_sel && (state_reg != RUN)) begin
        mod_idx_reg <= mod_index;
      end
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        q_reg   <= q;
        r_reg   <= '0;
        cnt_reg <= CW'(ITER - 1);
      end else if (state_reg == RUN) begin
        r_reg <= r2;
        if (last_iter) begin
          c_reg <= r2;
        end else begin
          cnt_reg <= cnt_reg - CW'(1);
        end
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign c    = c_reg;

endmodule

// File: tb/tb_modular_multiplier_seq.sv
// Directed and random checks of modular_multiplier_seq against hand-computed values and a golden (a*b)%Q model.

module tb_modular_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mod_sel;
  logic [3:0]  mod_index;
  logic        start;
  logic [29:0] a, b;
  logic        busy, done;
  logic [29:0] c;

  int total = 0;
  int bad   = 0;
  logic [29:0] q_tab [16];

  always #5 clk = ~clk;

  modular_multiplier_seq dut (
    .clk       (clk),
    .rst       (rst),
    .mod_sel   (mod_sel),
    .mod_index (mod_index),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .c         (c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_mod(input int k);
    mod_sel   = 1'b1;
    mod_index = 4'(k);
    @(posedge clk); #1;
    mod_sel   = 1'b0;
  endtask

  // Issues start at the next edge and returns in the done cycle (or after a timeout).
  task automatic do_op(input string tag, input logic [29:0] av, input logic [29:0] bv,
                       input logic [29:0] exp);
    int n, nb, both;
    bit seen;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; nb = busy ? 1 : 0; seen = done; both = (busy && done) ? 1 : 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
      if (busy && done) both++;
      if (done) seen = 1;
    end
    $display("op %s: a=%0d b=%0d c=%0d latency=%0d", tag, av, bv, c, n);
    check({tag, "_latency"}, 64'(n), 64'd31);
    check({tag, "_busy_cycles"}, 64'(nb), 64'd30);
    check({tag, "_overlap"}, 64'(both), 64'd0);
    check({tag, "_c"}, 64'(c), 64'(exp));
  endtask

  initial begin
    int kl [3];
    int n, dones, first_n;
    logic [29:0] qk, ra, rb, held;
    logic [63:0] prod;

    q_tab = '{30'd998244353, 30'd469762049, 30'd167772161, 30'd754974721,
              30'd1004535809, 30'd1012924417, 30'd924844033, 30'd962592769,
              30'd950009857, 30'd943718401, 30'd935329793, 30'd897581057,
              30'd880803841, 30'd645922817, 30'd595591169, 30'd1073479681};
    kl = '{0, 1, 15};

    rst = 1'b1; mod_sel = 1'b0; mod_index = '0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_c", 64'(c), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("basic", 30'd2, 30'd3, 30'd6);
    @(posedge clk); #1;
    check("basic_done_one_cycle", 64'(done), 64'd0);

    foreach (kl[i]) begin
      set_mod(kl[i]);
      qk = q_tab[kl[i]];
      do_op($sformatf("k%0d_max", kl[i]), qk - 30'd1, qk - 30'd1, 30'd1);
      do_op($sformatf("k%0d_zero", kl[i]), 30'd0, qk - 30'd1, 30'd0);
      do_op($sformatf("k%0d_one", kl[i]), 30'd1, 30'd12345, 30'd12345);
    end

    // Back-to-back: the second start is issued in the done cycle of the first.
    set_mod(0);
    do_op("b2b_first", 30'd123456, 30'd654321, 30'd920305136);
    held = c;
    do_op("b2b_second", 30'd5, 30'd7, 30'd35);
    check("b2b_first_held", 64'(held), 64'd920305136);

    // mod_sel and start during RUN must be ignored.
    a = q_tab[0] - 30'd1; b = 30'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; first_n = 0;
    for (n = 1; n <= 45; n++) begin
      if (n == 10) begin
        mod_sel = 1'b1; mod_index = 4'd15; start = 1'b1; a = 30'd7; b = 30'd7;
      end
      if (done) begin
        dones++;
        if (first_n == 0) begin
          first_n = n;
          check("ignore_c", 64'(c), 64'(q_tab[0] - 30'd2));
        end
      end
      @(posedge clk); #1;
      if (n == 10) begin
        mod_sel = 1'b0; start = 1'b0;
      end
    end
    $display("op ignore: dones=%0d first_done=%0d c=%0d", dones, first_n, c);
    check("ignore_dones", 64'(dones), 64'd1);
    check("ignore_latency", 64'(first_n), 64'd31);
    do_op("ignore_idx_kept", q_tab[0] - 30'd1, 30'd2, q_tab[0] - 30'd2);

    // Reset mid-RUN aborts the operation and clears the modulus index.
    set_mod(15);
    a = 30'd1000; b = 30'd1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_c", 64'(c), 64'd0);
    dones = 0;
    repeat (40) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    $display("op abort: dones=%0d c=%0d", dones, c);
    check("abort_no_done", 64'(dones), 64'd0);
    do_op("after_abort", 30'd123456, 30'd654321, 30'd920305136);

    // Random operands below Q across all indices.
    for (int t = 0; t < 200; t++) begin
      int k;
      k  = $urandom_range(0, 15);
      qk = q_tab[k];
      ra = 30'($urandom_range(0, 32'(qk) - 1));
      rb = 30'($urandom_range(0, 32'(qk) - 1));
      prod = (64'(ra) * 64'(rb)) % 64'(qk);
      set_mod(k);
      do_op($sformatf("rand%0d_k%0d", t, k), ra, rb, 30'(prod));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
